// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI transaction sequencer.
//   xfer_state_t   : sequencer FSM states
//   DEFAULT_CS_DLY : value the CS delay timer holds out of reset
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,  // waiting for a command (CS may still be held)
    GAP   = 3'd1,  // one all-high cycle when switching away from a held CS
    SETUP = 3'd2,  // CS asserted, waiting cs_setup+1 cycles
    ISSUE = 3'd3,  // offering a byte to the byte engine
    WAIT  = 3'd4,  // byte in flight, waiting for byte-done
    HOLD  = 3'd5   // last byte done, waiting cs_hold+1 cycles
  } xfer_state_t;

  localparam int DEFAULT_CS_DLY = 0;

endpackage

// File: rtl/spi_cs_timer.sv
// Loadable down-counter used for both the CS setup and CS hold intervals.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture load_val (takes priority over counting)
//   load_val  : number of extra cycles to wait
//   run       : count down while nonzero
//   expired   : counter has reached zero
// Loading N while the owning state is entered gives N+1 cycles in that state,
// because the state leaves on the first cycle it sees expired.
module spi_cs_timer
  import spi_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             run,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= WIDTH'(DEFAULT_CS_DLY);
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (run && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - WIDTH'(1);
    end
  end

  assign expired = (cnt_reg == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Transaction sequencer in front of an 8-bit SPI byte engine.
// Turns one command into cmd_len+1 back-to-back byte transfers, owns the
// active-low chip selects and enforces CS setup/hold delays. A command with
// cmd_keep set leaves its CS asserted so a follow-up command to the same
// device continues the transaction without a new setup interval.
//   command : cmd_len, cmd_cs, cmd_keep, cmd_vld / cmd_rdy
//   config  : cs_setup, cs_hold (sampled when SETUP/HOLD is entered)
//   tx      : tx_data, tx_vld / tx_rdy (passthrough to the engine in ISSUE)
//   rx      : rx_data, rx_vld (one-cycle pulse per received byte)
//   status  : busy, csn
//   engine  : m_din, m_din_vld, m_din_rdy, m_dout, m_dout_vld
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_CS    = 4,
  parameter int LEN_WIDTH = 8,
  parameter int DLY_WIDTH = 8,
  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic [CS_W-1:0]      cmd_cs,
  input  logic                 cmd_keep,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  input  logic [DLY_WIDTH-1:0] cs_setup,
  input  logic [DLY_WIDTH-1:0] cs_hold,
  input  logic [7:0]           tx_data,
  input  logic                 tx_vld,
  output logic                 tx_rdy,
  output logic [7:0]           rx_data,
  output logic                 rx_vld,
  output logic                 busy,
  output logic [NUM_CS-1:0]    csn,
  output logic [7:0]           m_din,
  output logic                 m_din_vld,
  input  logic                 m_din_rdy,
  input  logic [7:0]           m_dout,
  input  logic                 m_dout_vld
);

  xfer_state_t          state_reg, state_next;
  logic [LEN_WIDTH-1:0] len_reg, len_next;
  logic [LEN_WIDTH-1:0] cnt_reg, cnt_next;
  logic [CS_W-1:0]      cs_reg, cs_next;
  logic                 keep_reg, keep_next;
  logic                 held_reg, held_next;
  logic [7:0]           rx_data_reg, rx_data_next;
  logic                 rx_vld_reg, rx_vld_next;
  logic [NUM_CS-1:0]    csn_reg, csn_next;

  logic [CS_W-1:0]      cs_sel;
  logic                 cs_active;
  logic                 timer_load;
  logic [DLY_WIDTH-1:0] timer_val;
  logic                 timer_run;
  logic                 timer_expired;

  // Out-of-range chip-select indices fall back to device 0. The compare only
  // exists when the index field can actually encode an out-of-range value.
  generate
    if ((1 << CS_W) > NUM_CS) begin : g_cs_clamp
      assign cs_sel = (cmd_cs < CS_W'(NUM_CS)) ? cmd_cs : '0;
    end else begin : g_cs_direct
      assign cs_sel = cmd_cs;
    end
  endgenerate

  assign timer_run = (state_reg == SETUP) || (state_reg == HOLD);

  spi_cs_timer #(
    .WIDTH (DLY_WIDTH)
  ) u_cs_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .run      (timer_run),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      len_reg     <= '0;
      cnt_reg     <= '0;
      cs_reg      <= '0;
      keep_reg    <= 1'b0;
      held_reg    <= 1'b0;
      rx_data_reg <= '0;
      rx_vld_reg  <= 1'b0;
      csn_reg     <= '1;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      cnt_reg     <= cnt_next;
      cs_reg      <= cs_next;
      keep_reg    <= keep_next;
      held_reg    <= held_next;
      rx_data_reg <= rx_data_next;
      rx_vld_reg  <= rx_vld_next;
      csn_reg     <= csn_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    cnt_next     = cnt_reg;
    cs_next      = cs_reg;
    keep_next    = keep_reg;
    held_next    = held_reg;
    rx_data_next = rx_data_reg;
    rx_vld_next  = 1'b0;
    cmd_rdy      = 1'b0;
    tx_rdy       = 1'b0;
    m_din_vld    = 1'b0;
    timer_load   = 1'b0;
    timer_val    = cs_setup;

    case (state_reg)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_vld) begin
          len_next  = cmd_len;
          cs_next   = cs_sel;
          keep_next = cmd_keep;
          cnt_next  = '0;
          held_next = 1'b0;
          if (held_reg && (cs_sel == cs_reg)) begin
            // Continuing a kept transaction on the same device.
            state_next = ISSUE;
          end else if (held_reg) begin
            // Different device: release the held CS for one cycle first.
            state_next = GAP;
          end else begin
            state_next = SETUP;
            timer_load = 1'b1;
            timer_val  = cs_setup;
          end
        end
      end

      GAP: begin
        state_next = SETUP;
        timer_load = 1'b1;
        timer_val  = cs_setup;
      end

      SETUP: begin
        if (timer_expired) begin
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        m_din_vld = tx_vld;
        tx_rdy    = m_din_rdy;
        if (m_din_rdy) begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (m_dout_vld) begin
          rx_data_next = m_dout;
          rx_vld_next  = 1'b1;
          if (cnt_reg == len_reg) begin
            state_next = HOLD;
            timer_load = 1'b1;
            timer_val  = cs_hold;
          end else begin
            cnt_next   = cnt_reg + LEN_WIDTH'(1);
            state_next = ISSUE;
          end
        end
      end

      HOLD: begin
        if (timer_expired) begin
          state_next = IDLE;
          held_next  = keep_reg;
        end
      end

      default: begin
        state_next = IDLE;
        held_next  = 1'b0;
      end
    endcase
  end

  // CS is decoded from the next state so csn is a clean register output and
  // changes in the same cycle the FSM moves.
  assign cs_active = (state_next == SETUP) || (state_next == ISSUE) ||
                     (state_next == WAIT)  || (state_next == HOLD)  ||
                     ((state_next == IDLE) && held_next);

  generate
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_csn
      assign csn_next[gi] = ~(cs_active && (cs_next == CS_W'(gi)));
    end
  endgenerate

  assign m_din   = tx_data;
  assign rx_data = rx_data_reg;
  assign rx_vld  = rx_vld_reg;
  assign csn     = csn_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a small byte-engine model in loopback.
// Engine model timing: it accepts a byte on the first edge it sees m_din_vld
// (din_rdy high for the following cycle) and pulses dout_vld with the same
// byte 4 edges after that accept. With that model each byte costs
// ISSUE 2 cycles + WAIT 4 cycles.
module tb_spi_xfer_ctrl;

  localparam int NUM_CS = 4;
  localparam int XFER   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cmd_len = '0;
  logic [1:0] cmd_cs = '0;
  logic       cmd_keep = 1'b0;
  logic       cmd_vld = 1'b0;
  logic       cmd_rdy;
  logic [7:0] cs_setup = 8'd3;
  logic [7:0] cs_hold = 8'd2;
  logic [7:0] tx_data = '0;
  logic       tx_vld = 1'b0;
  logic       tx_rdy;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       busy;
  logic [3:0] csn;
  logic [7:0] m_din;
  logic       m_din_vld;
  logic       m_din_rdy;
  logic [7:0] m_dout;
  logic       m_dout_vld;

  spi_xfer_ctrl #(.NUM_CS(NUM_CS), .LEN_WIDTH(8), .DLY_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_len(cmd_len), .cmd_cs(cmd_cs), .cmd_keep(cmd_keep),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cs_setup(cs_setup), .cs_hold(cs_hold),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .rx_data(rx_data), .rx_vld(rx_vld), .busy(busy), .csn(csn),
    .m_din(m_din), .m_din_vld(m_din_vld), .m_din_rdy(m_din_rdy),
    .m_dout(m_dout), .m_dout_vld(m_dout_vld)
  );

  always #5 clk = ~clk;

  // Byte engine model (shares the reset, loopback miso=mosi).
  logic [7:0] m_byte;
  int         m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_din_rdy  <= 1'b0;
      m_dout_vld <= 1'b0;
      m_dout     <= '0;
      m_byte     <= '0;
      m_cnt      <= 0;
    end else begin
      m_din_rdy  <= 1'b0;
      m_dout_vld <= 1'b0;
      if (m_cnt == 0 && !m_din_rdy && m_din_vld) begin
        m_din_rdy <= 1'b1;
        m_byte    <= m_din;
        m_cnt     <= XFER;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_dout_vld <= 1'b1;
          m_dout     <= m_byte;
        end
      end
    end
  end

  // Monitor: sampled on the falling edge, counters only ever increase.
  logic [7:0] rx_log [0:1023];
  int rx_total = 0, tx_total = 0, low_total = 0, hi_total = 0, multi_low = 0;
  int since = 0, last_gap = -1;
  bit armed = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_vld) begin
        rx_log[rx_total] = rx_data;
        rx_total++;
      end
      if (tx_rdy) tx_total++;
      if (csn != 4'hF) low_total++; else hi_total++;
      if ($countones(~csn) > 1) multi_low++;
      if (m_dout_vld) begin
        since = 0;
        armed = 1'b1;
      end else if (armed) begin
        since++;
        if (m_din_vld) begin
          last_gap = since;
          armed    = 1'b0;
        end
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] len, input logic [1:0] cs, input logic keep);
    int k = 0;
    cmd_len  = len;
    cmd_cs   = cs;
    cmd_keep = keep;
    cmd_vld  = 1'b1;
    while (!cmd_rdy && k < 100) begin
      tick();
      k++;
    end
    chk("cmd_accept_timeout", 32'(k < 100), 32'd1);
    tick();
    cmd_vld = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      tx_data = 8'(first + i);
      tx_vld  = 1'b1;
      while (!tx_rdy && k < 200) begin
        tick();
        k++;
      end
      if (k >= 200) begin
        chk("tx_rdy_timeout", 32'(k), 32'd0);
        break;
      end
      tick();
    end
    tx_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 5000) begin
      tick();
      k++;
    end
    chk("idle_timeout", 32'(k < 5000), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0, tx0, low0, hi0, bad;

    // Reset state
    tick(); tick();
    chk("rst_csn", 32'(csn), 32'hF);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_vld", 32'(rx_vld), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_din_vld", 32'(m_din_vld), 32'd0);
    chk("rst_tx_rdy", 32'(tx_rdy), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single byte, setup 3 (4 cycles) + ISSUE 2 + WAIT 4 + hold 2 (3 cycles) = 13
    rx0 = rx_total; tx0 = tx_total; low0 = low_total;
    send_cmd(8'd0, 2'd1, 1'b0);
    chk("t1_csn_after_accept", 32'(csn), 32'hD);
    chk("t1_busy", 32'(busy), 32'd1);
    feed(1, 8'hA5);
    wait_idle();
    chk("t1_cs_low_cycles", 32'(low_total - low0), 32'd13);
    chk("t1_rx_count", 32'(rx_total - rx0), 32'd1);
    chk("t1_rx_byte", 32'(rx_log[rx0]), 32'hA5);
    chk("t1_tx_rdy_count", 32'(tx_total - tx0), 32'd1);
    chk("t1_csn_released", 32'(csn), 32'hF);

    // 2: four bytes, CS continuous, one cycle from byte-done to next din_vld
    rx0 = rx_total; tx0 = tx_total;
    send_cmd(8'd3, 2'd1, 1'b0);
    hi0 = hi_total;
    feed(4, 8'h01);
    wait_idle();
    chk("t2_cs_continuous", 32'(hi_total - hi0), 32'd0);
    chk("t2_rx_count", 32'(rx_total - rx0), 32'd4);
    chk("t2_tx_rdy_count", 32'(tx_total - tx0), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_rx_byte", 32'(rx_log[rx0 + i]), 32'(i + 1));
    chk("t2_byte_gap", 32'(last_gap), 32'd1);

    // 3: keep CS on device 2, continue without setup, then switch to device 0
    rx0 = rx_total;
    send_cmd(8'd0, 2'd2, 1'b1);
    feed(1, 8'h10);
    wait_idle();
    chk("t3_held_csn", 32'(csn), 32'hB);
    chk("t3_held_cmd_rdy", 32'(cmd_rdy), 32'd1);
    tx_data = 8'h11;
    tx_vld  = 1'b1;
    hi0 = hi_total;
    send_cmd(8'd0, 2'd2, 1'b1);
    chk("t3_no_setup_din_vld", 32'(m_din_vld), 32'd1);
    chk("t3_cont_csn", 32'(csn), 32'hB);
    feed(1, 8'h11);
    wait_idle();
    chk("t3_cs_never_rose", 32'(hi_total - hi0), 32'd0);
    chk("t3_held_again_csn", 32'(csn), 32'hB);
    send_cmd(8'd0, 2'd0, 1'b0);
    chk("t3_gap_csn", 32'(csn), 32'hF);
    chk("t3_gap_busy", 32'(busy), 32'd1);
    tick();
    chk("t3_new_cs_csn", 32'(csn), 32'hE);
    chk("t3_setup_din_vld", 32'(m_din_vld), 32'd0);
    feed(1, 8'h12);
    wait_idle();
    chk("t3_csn_released", 32'(csn), 32'hF);
    for (int i = 0; i < 3; i++) chk("t3_rx_byte", 32'(rx_log[rx0 + i]), 32'(8'h10 + i));

    // 4: tx_vld low for 20 cycles while in ISSUE
    rx0 = rx_total;
    tx_vld = 1'b0;
    send_cmd(8'd0, 2'd3, 1'b0);
    repeat (24) tick();
    chk("t4_stall_din_vld", 32'(m_din_vld), 32'd0);
    chk("t4_stall_csn", 32'(csn), 32'h7);
    chk("t4_stall_no_rx", 32'(rx_total - rx0), 32'd0);
    chk("t4_stall_busy", 32'(busy), 32'd1);
    tx_data = 8'h5A;
    tx_vld  = 1'b1;
    #1;
    chk("t4_passthru_vld", 32'(m_din_vld), 32'd1);
    chk("t4_passthru_data", 32'(m_din), 32'h5A);
    feed(1, 8'h5A);
    wait_idle();
    chk("t4_rx_byte", 32'(rx_log[rx0]), 32'h5A);

    // 5: asynchronous reset while byte 2 of 4 is in flight
    send_cmd(8'd3, 2'd1, 1'b0);
    feed(1, 8'h21);
    tx_data = 8'h22;
    tx_vld  = 1'b1;
    begin
      int k = 0;
      while (!tx_rdy && k < 200) begin
        tick();
        k++;
      end
      chk("t5_tx_rdy_timeout", 32'(k < 200), 32'd1);
    end
    tick();
    tx_vld = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_csn", 32'(csn), 32'hF);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    rx0 = rx_total;
    send_cmd(8'd1, 2'd0, 1'b0);
    feed(2, 8'h31);
    wait_idle();
    chk("t5_rx_count", 32'(rx_total - rx0), 32'd2);
    chk("t5_rx_byte0", 32'(rx_log[rx0]), 32'h31);
    chk("t5_rx_byte1", 32'(rx_log[rx0 + 1]), 32'h32);

    // 6: 256 bytes, zero delays: setup 1 + 256*6 + hold 1 = 1538 low cycles
    cs_setup = 8'd0;
    cs_hold  = 8'd0;
    rx0 = rx_total; low0 = low_total;
    tx_data = 8'h00;
    tx_vld  = 1'b1;
    send_cmd(8'hFF, 2'd2, 1'b0);
    chk("t6_setup_din_vld", 32'(m_din_vld), 32'd0);
    chk("t6_setup_csn", 32'(csn), 32'hB);
    tick();
    chk("t6_issue_din_vld", 32'(m_din_vld), 32'd1);
    feed(256, 8'h00);
    wait_idle();
    chk("t6_rx_count", 32'(rx_total - rx0), 32'd256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (rx_log[rx0 + i] !== 8'(i)) bad++;
    chk("t6_rx_bytes_bad", 32'(bad), 32'd0);
    chk("t6_cs_low_cycles", 32'(low_total - low0), 32'd1538);
    chk("t6_csn_released", 32'(csn), 32'hF);
    chk("t6_cmd_rdy", 32'(cmd_rdy), 32'd1);

    chk("one_hot_csn", 32'(multi_low), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transaction sequencer that sits between a host-side command/data stream and the 8-bit spi_master byte engine. It owns the chip-select lines, turns one command into N back-to-back byte transfers, and enforces programmable CS setup and hold times. It forwards received bytes and can keep CS asserted across commands for multi-phase transactions (opcode, then payload).

Parameters:
NUM_CS, 4, number of active-low chip selects
LEN_WIDTH, 8, width of byte-count field (transfer length = cmd_len+1)
DLY_WIDTH, 8, width of CS setup/hold delay fields (clk cycles)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd_len  in  LEN_WIDTH  bytes in transaction minus one
cmd_cs  in  $clog2(NUM_CS)  target chip-select index
cmd_keep  in  1  keep CS asserted after last byte
cmd_vld  in  1  command valid
cmd_rdy  out  1  command accepted when cmd_vld&&cmd_rdy
cs_setup  in  DLY_WIDTH  CS-assert-to-first-byte delay (static config)
cs_hold  in  DLY_WIDTH  last-byte-to-CS-release delay (static config)
tx_data  in  8  byte to transmit
tx_vld  in  1  tx byte valid
tx_rdy  out  1  tx byte consumed this cycle
rx_data  out  8  received byte
rx_vld  out  1  one-cycle pulse, rx_data valid (no back-pressure)
busy  out  1  state != IDLE
csn  out  NUM_CS  chip selects, active low
m_din  out  8  to spi_master din
m_din_vld  out  1  to spi_master din_vld
m_din_rdy  in  1  from spi_master din_rdy (accept pulse)
m_dout  in  8  from spi_master dout
m_dout_vld  in  1  from spi_master dout_vld (byte-done pulse)

Behaviour:
- Reset (async assert, sync release): state IDLE, csn all ones, cmd_rdy=1, m_din_vld=0, tx_rdy=0, rx_vld=0, rx_data=0, busy=0, keep flag cleared, byte counter 0.
- States: IDLE, GAP, SETUP, ISSUE, WAIT, HOLD.
- IDLE: cmd_rdy=1. On accept, latch len/cs/keep. If CS is still held from a kept command and cmd_cs equals the held index -> ISSUE (no setup). If held with a different index -> GAP. Otherwise -> SETUP. csn[cmd_cs] goes low in the cycle after accept.
- GAP: all csn high for exactly 1 cycle -> SETUP.
- SETUP: selected csn low; lasts cs_setup+1 cycles, so cs_setup=0 gives 1 cycle -> ISSUE.
- ISSUE: m_din=tx_data, m_din_vld=tx_vld, tx_rdy=m_din_rdy (combinational passthrough). On m_din_rdy -> WAIT. If tx_vld stays low, stall indefinitely with CS asserted.
- WAIT: m_din_vld=0. On m_dout_vld: rx_data<=m_dout and rx_vld=1 next cycle. If counter==len -> HOLD, else counter+1 -> ISSUE.
- HOLD: CS low for cs_hold+1 cycles. Then, if keep: CS stays low, held flag set, -> IDLE. Else csn all ones, held flag cleared, -> IDLE.
- m_din_vld is never asserted outside ISSUE, so at most one byte is outstanding. Per-byte overhead beyond spi_master time is 1 cycle.
- Exactly one csn bit is low at any time, and only from SETUP/ISSUE/WAIT/HOLD or in the held state. cmd_cs >= NUM_CS is treated as index 0.
- Counter wraps cleanly: cmd_len=all-ones transfers 2^LEN_WIDTH bytes. Compare with ==, never overflow-dependent.
- m_dout_vld outside WAIT is ignored.
- cs_setup and cs_hold are sampled at entry to SETUP/HOLD. Changes mid-count are ignored.
- Reset mid-transfer releases all CS immediately (async). The spi_master must share the same reset so it does not finish a stale byte.

Decomposition:
- Package spi_ctrl_pkg holds the state enum typedef (IDLE, GAP, SETUP, ISSUE, WAIT, HOLD) and a default-delay localparam.
- One sub-module: spi_cs_timer, a loadable down-counter (load value, start, expired) reused for SETUP and HOLD.
- Byte counter and FSM live in spi_xfer_ctrl.

Test Plan:
- cs_setup=3, cs_hold=2, cmd_len=0, cs=1, tx=0xA5; spi_master loopback (miso=mosi) -> csn=4'b1101 for 4 setup + transfer + 3 hold cycles, then 4'b1111; one rx_vld with 0xA5; exactly one tx_rdy.
- cmd_len=3, bytes 0x01..0x04 -> four tx_rdy and four rx_vld in order 0x01..0x04; CS low continuously; gap between m_dout_vld and the next m_din_rdy is 1 cycle.
- cmd_keep=1, len=0, cs=2, then second cmd cs=2 -> no SETUP on the second command, csn[2] never rises between commands. Third cmd cs=0 -> 1-cycle all-high GAP, then csn[0] low.
- tx_vld held low 20 cycles in ISSUE -> m_din_vld=0, CS held low, no rx_vld; resumes correctly when tx_vld rises.
- Async rst pulse during WAIT of byte 2 of 4 -> csn=all ones same cycle, busy=0, cmd_rdy=1; a new command after release completes normally.
- cmd_len=255 (LEN_WIDTH=8) -> exactly 256 rx_vld pulses, then IDLE; cs_setup=cs_hold=0 gives 1-cycle setup and 1-cycle hold.
